// File: rtl/demux_32bit_buf.sv
// Buffered 1:2 demux: one valid/ready input steered by in_sel into two FIFOs.
// Optional pop counters on each output when DEMUX_STATS_EN is defined.
module demux_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]      y0_count,
  output logic [15:0]      y1_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]   mem [2][DEPTH];
  logic [1:0][AW-1:0] wp;
  logic [1:0][AW-1:0] rp;
  logic [1:0][AW:0]   cnt;
  logic [1:0]         full;
  logic [1:0]         valid;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         rdy;

  always_comb begin
    full  = '0;
    valid = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (cnt[i] == FULL_CNT);
      valid[i] = (cnt[i] != '0);
    end
  end

  // Ready depends only on the selected FIFO, so a full
  // sibling never stalls traffic to the other side.
  assign in_ready = ~full[in_sel];
  assign rdy      = {y1_ready, y0_ready};
  assign pop      = valid & rdy;
  assign push     = {in_valid & in_ready & in_sel,
                     in_valid & in_ready & ~in_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= in_data;
          wp[i]         <= wp[i] + AW'(1);
        end
        if (pop[i])
          rp[i] <= rp[i] + AW'(1);
        unique case (1'b1)
          push[i] & ~pop[i]: cnt[i] <= cnt[i] + 1'b1;
          pop[i] & ~push[i]: cnt[i] <= cnt[i] - 1'b1;
          default:           cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign y0_data  = mem[0][rp[0]];
  assign y1_data  = mem[1][rp[1]];
  assign y0_valid = valid[0];
  assign y1_valid = valid[1];

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_count <= '0;
      y1_count <= '0;
    end else begin
      if (pop[0] && y0_count != 16'hFFFF)
        y0_count <= y0_count + 16'd1;
      if (pop[1] && y1_count != 16'hFFFF)
        y1_count <= y1_count + 16'd1;
    end
  end
`endif

endmodule
